vga_controller: RTL

VGA_CONTROLLER -- requirements
Module: vga_controller

---
 rtl/vga_pkg.sv | 32 +++
 rtl/vga_axis_counter.sv | 72 +++++++
 rtl/vga_controller.sv | 121 ++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA timing generator: the per-axis phase
// encoding, the counter width and the default 640x480@60 timing constants.
// No ports (package).
// -----------------------------------------------------------------------------
package vga_pkg;

  localparam int CNT_W = 11;

  typedef enum logic [1:0] {
    PH_ACT   = 2'd0,
    PH_FRONT = 2'd1,
    PH_SYN   = 2'd2,
    PH_BACK  = 2'd3
  } phase_t;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  function automatic int axis_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
// One timing axis: a counter over 0..TOTAL-1 plus the phase FSM that tracks
// which interval the count is in. Used once per line (horizontal) and once
// per frame (vertical).
//
// state    | meaning
// ---------+------------------------------------------
// PH_ACT   | count in visible interval
// PH_FRONT | count in front porch
// PH_SYN   | count in sync pulse
// PH_BACK  | count in back porch
//
// Ports:
//   clk    in   clock
//   rst_b  in   synchronous active-low reset
//   step   in   advance count/phase this cycle
//   count  out  current position on the axis
//   phase  out  interval the current count lies in
//   wrap   out  high in a step cycle where count is at TOTAL-1
// -----------------------------------------------------------------------------
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = H_ACTIVE_DEF,
  parameter int FP     = H_FP_DEF,
  parameter int SYNC   = H_SYNC_DEF,
  parameter int BP     = H_BP_DEF
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             step,
  output logic [CNT_W-1:0] count,
  output phase_t           phase,
  output logic             wrap
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

  localparam logic [CNT_W-1:0] LAST_ACT   = CNT_W'(ACTIVE - 1);
  localparam logic [CNT_W-1:0] LAST_FRONT = CNT_W'(ACTIVE + FP - 1);
  localparam logic [CNT_W-1:0] LAST_SYN   = CNT_W'(ACTIVE + FP + SYNC - 1);
  localparam logic [CNT_W-1:0] LAST_BACK  = CNT_W'(TOTAL - 1);

  phase_t phase_nxt;

  assign wrap = step && (count == LAST_BACK);

  // Phase leaves an interval on the step that moves count past its last value,
  // so phase always describes the count it sits next to.
  always_comb begin
    phase_nxt = phase;
    case (phase)
      PH_ACT:   if (count == LAST_ACT)   phase_nxt = PH_FRONT;
      PH_FRONT: if (count == LAST_FRONT) phase_nxt = PH_SYN;
      PH_SYN:   if (count == LAST_SYN)   phase_nxt = PH_BACK;
      PH_BACK:  if (count == LAST_BACK)  phase_nxt = PH_ACT;
      default:  phase_nxt = PH_ACT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      count <= '0;
      phase <= PH_ACT;
    end else if (step) begin
      count <= wrap ? '0 : count + CNT_W'(1);
      phase <= phase_nxt;
    end
  end

endmodule

// File: rtl/vga_controller.sv
// -----------------------------------------------------------------------------
// vga_controller
// VGA raster timing generator with registered colour/sync/blank outputs.
// Pixel source is expected to return colour combinationally for the current
// o_VGA_X/o_VGA_Y; colour, blank and sync are all registered on the same
// enable so they stay aligned, one pixel behind the coordinates.
//
// Ports:
//   i_clk           in   clock
//   i_reset         in   synchronous active-low reset
//   i_pix_en        in   pixel-advance enable
//   i_VGA_R/G/B     in   8-bit colour for current coordinate
//   o_VGA_X/Y       out  11-bit horizontal/vertical count
//   o_VGA_R/G/B     out  registered colour, 0 outside active area
//   o_VGA_HS/VS     out  active-low sync
//   o_VGA_BLANK_N   out  low outside active area
//   o_VGA_SYNC_N    out  constant 0
//   o_frame_start   out  pulse on the enable cycle at (0,0)
//   o_vblank_start  out  pulse on the enable cycle at the last pixel of the
//                        last active line
// -----------------------------------------------------------------------------
module vga_controller
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_pix_en,
  input  logic [7:0]  i_VGA_R,
  input  logic [7:0]  i_VGA_G,
  input  logic [7:0]  i_VGA_B,
  output logic [10:0] o_VGA_X,
  output logic [10:0] o_VGA_Y,
  output logic [7:0]  o_VGA_R,
  output logic [7:0]  o_VGA_G,
  output logic [7:0]  o_VGA_B,
  output logic        o_VGA_HS,
  output logic        o_VGA_VS,
  output logic        o_VGA_BLANK_N,
  output logic        o_VGA_SYNC_N,
  output logic        o_frame_start,
  output logic        o_vblank_start
);

  localparam logic [CNT_W-1:0] V_LAST_ACT = CNT_W'(V_ACTIVE - 1);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  phase_t           h_phase;
  phase_t           v_phase;
  logic             h_wrap;
  logic             v_wrap_unused;  // frame wrap is decoded from counts instead
  logic             active;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_axis (
    .clk    (i_clk),
    .rst_b  (i_reset),
    .step   (i_pix_en),
    .count  (h_cnt),
    .phase  (h_phase),
    .wrap   (h_wrap)
  );

  // Vertical axis steps once per line, on the horizontal wrap.
  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_axis (
    .clk    (i_clk),
    .rst_b  (i_reset),
    .step   (h_wrap),
    .count  (v_cnt),
    .phase  (v_phase),
    .wrap   (v_wrap_unused)
  );

  assign o_VGA_X      = h_cnt;
  assign o_VGA_Y      = v_cnt;
  assign o_VGA_SYNC_N = 1'b0;

  assign active = (h_phase == PH_ACT) && (v_phase == PH_ACT);

  // Pulses are decoded from registered counts and qualified by the enable, so
  // they last exactly one clock; reset forces them low in the reset cycle.
  assign o_frame_start  = i_reset && i_pix_en && (h_cnt == '0) && (v_cnt == '0);
  assign o_vblank_start = i_reset && h_wrap && (v_cnt == V_LAST_ACT);

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      o_VGA_R       <= '0;
      o_VGA_G       <= '0;
      o_VGA_B       <= '0;
      o_VGA_BLANK_N <= 1'b0;
      o_VGA_HS      <= 1'b1;
      o_VGA_VS      <= 1'b1;
    end else if (i_pix_en) begin
      o_VGA_R       <= active ? i_VGA_R : 8'd0;
      o_VGA_G       <= active ? i_VGA_G : 8'd0;
      o_VGA_B       <= active ? i_VGA_B : 8'd0;
      o_VGA_BLANK_N <= active;
      o_VGA_HS      <= (h_phase != PH_SYN);
      o_VGA_VS      <= (v_phase != PH_SYN);
    end
  end

endmodule
